// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the synchronous data memory (dmem_sync):
//   - RV32 load/store funct3 size/sign codes
//   - FSM state type for the request/response sequencer
//   - store_mask(): byte-lane enable pattern for a store size code
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Lanes are relative to the access base address, lane 0 = lowest byte.
  function automatic logic [3:0] store_mask(input logic [2:0] funct3);
    logic [3:0] mask;
    case (funct3)
      F3_B:    mask = 4'b0001;
      F3_H:    mask = 4'b0011;
      F3_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_sync_if.sv
// ---------------------------------------------------------------------------
// dmem_sync_if
// Request/response bus between a load/store master and dmem_sync.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32 size/sign code
//   req_addr/req_wdata  : byte address / store data (little-endian lanes)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : load result / access fault (qualified by rsp_valid)
// Modports: master (requester side), slave (memory side).
// ---------------------------------------------------------------------------
interface dmem_sync_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank
// Byte-addressed storage of 2**ADDR_W bytes. Reads four consecutive bytes
// combinationally starting at addr_i; writes up to four consecutive bytes on
// the rising clock edge under per-lane enables. Lane addresses wrap modulo
// 2**ADDR_W. Contents are never reset.
// Ports:
//   clk_i   : clock
//   be_i    : byte-lane write enables (lane k -> addr_i + k)
//   addr_i  : base byte address
//   wdata_i : write data, lane k = wdata_i[8k+7:8k]
//   rdata_o : read data, lane k = byte at addr_i + k
// ---------------------------------------------------------------------------
module dmem_bank #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [7:0]        mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] laneAddr [4];

  // Lane addresses rely on ADDR_W-bit overflow for the modulo wrap.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      laneAddr[k] = addr_i + ADDR_W'(k);
    end
  end

  // Combinational 4-byte read, little-endian assembly.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      rdata_o[8*k +: 8] = mem_q[laneAddr[k]];
    end
  end

  // Storage write; no reset so contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (be_i[k]) begin
        mem_q[laneAddr[k]] <= wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_sync.sv
// ---------------------------------------------------------------------------
// dmem_sync
// Synchronous data memory with an RV32 load/store request/response interface
// and WAIT_CYC configurable wait states. One request is in flight at a time:
// IDLE accepts, WAIT counts wait states, RESP holds the response until the
// consumer takes it. Stores commit and loads are captured on the edge that
// enters RESP.
// Parameters:
//   ADDR_W   : byte-address width (storage depth 2**ADDR_W bytes)
//   WAIT_CYC : extra wait states, 0..15
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : dmem_sync_if.slave request/response bus
// Build option:
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//   fault; otherwise they are performed bytewise with address wrap.
// ---------------------------------------------------------------------------
module dmem_sync #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_sync_if.slave bus
);
  import dmem_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        commit;
  logic        opWe;
  logic [2:0]  opFunct3;
  logic [31:0] opAddr;
  logic [31:0] opWdata;
  logic        outOfRange;
  logic        badFunct3;
  logic        misaligned;
  logic        accessErr;
  logic [3:0]  bankBe;
  logic [31:0] bankRdata;
  logic [31:0] loadData;

  assign accept = (state_q == ST_IDLE) && bus.req_valid && !rst;

  // With WAIT_CYC = 0 the access completes on the accept edge itself, so the
  // operation must come straight from the bus while in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      opWe     = bus.req_we;
      opFunct3 = bus.req_funct3;
      opAddr   = bus.req_addr;
      opWdata  = bus.req_wdata;
    end else begin
      opWe     = we_q;
      opFunct3 = funct3_q;
      opAddr   = addr_q;
      opWdata  = wdata_q;
    end
  end

  // Fault decode: address above storage, unsupported size code, and
  // optionally misalignment.
  always_comb begin
    outOfRange = (opAddr >> ADDR_W) != 32'd0;
    if (opWe) begin
      badFunct3 = !(opFunct3 inside {F3_B, F3_H, F3_W});
    end else begin
      badFunct3 = !(opFunct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = ((opFunct3[1:0] == 2'b01) && opAddr[0]) ||
                 ((opFunct3[1:0] == 2'b10) && (opAddr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    accessErr = outOfRange || badFunct3 || misaligned;
  end

  // Writes happen only on the commit edge and only for fault-free stores.
  assign bankBe = (commit && opWe && !accessErr) ? store_mask(opFunct3) : 4'b0000;

  dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk_i   (clk),
    .be_i    (bankBe),
    .addr_i  (opAddr[ADDR_W-1:0]),
    .wdata_i (opWdata),
    .rdata_o (bankRdata)
  );

  // Load size selection and sign/zero extension.
  always_comb begin
    case (opFunct3)
      F3_B:    loadData = {{24{bankRdata[7]}}, bankRdata[7:0]};
      F3_H:    loadData = {{16{bankRdata[15]}}, bankRdata[15:0]};
      F3_W:    loadData = bankRdata;
      F3_BU:   loadData = {24'd0, bankRdata[7:0]};
      F3_HU:   loadData = {16'd0, bankRdata[15:0]};
      default: loadData = 32'd0;
    endcase
  end

  // Next-state logic; the response registers load only on the commit edge
  // so they stay frozen throughout RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYC == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      err_d   = accessErr;
      rdata_d = (opWe || accessErr) ? 32'd0 : loadData;
    end
  end

  // State and response registers; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// ---------------------------------------------------------------------------
// tb_dmem_sync
// Self-checking bench for dmem_sync (ADDR_W = 16, WAIT_CYC = 2). A table of
// load/store vectors with constant expected results is pushed through the
// request bus; expected responses go into a scoreboard queue at accept time
// and are popped when the response appears. Hand-written sequences cover a
// stalled response and a reset during wait states.
// Expectations follow DMEM_MISALIGN_TRAP_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_dmem_sync;
  import dmem_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int WAIT_CYC = 2;
  localparam int TIMEOUT  = 40;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  dmem_sync_if bus();

  dmem_sync #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t scoreboard[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic void addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input logic expErr);
    vec_t v;
    v.we = we; v.funct3 = f3; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endfunction

  // Drive one request, wait (bounded) for the accept edge, record the
  // expected response. Returns #1 after the accept edge.
  task automatic applyStimulus(input vec_t v, input string name);
    bit   accepted;
    bit   wasReady;
    exp_t e;
    accepted       = 1'b0;
    bus.req_we     = v.we;
    bus.req_funct3 = v.funct3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    for (int n = 0; n < TIMEOUT; n++) begin
      wasReady = (bus.req_ready === 1'b1);
      @(posedge clk);
      #1;
      if (wasReady) begin
        accepted = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check({name, " accept"}, {31'd0, accepted}, 32'd1);
    e.rdata = v.expRdata;
    e.err   = v.expErr;
    scoreboard.push_back(e);
  endtask

  // Bounded wait for rsp_valid, counting cycles after the accept cycle.
  task automatic waitResponse(input string name);
    int lat;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, WAIT_CYC + 1);
  endtask

  // Pop the expected response, compare, then complete the handshake and
  // confirm the return to IDLE.
  task automatic checkOutput(input string name);
    exp_t e;
    if (scoreboard.size() == 0) begin
      check({name, " scoreboard"}, 32'd0, 32'd1);
      e.rdata = 32'd0;
      e.err   = 1'b0;
    end else begin
      e = scoreboard.pop_front();
    end
    check({name, " rdata"}, bus.rsp_rdata, e.rdata);
    check({name, " err"}, {31'd0, bus.rsp_err}, {31'd0, e.err});
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({name, " idle ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({name, " idle valid"}, {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic runOne(input vec_t v, input string name);
    applyStimulus(v, name);
    waitResponse(name);
    checkOutput(name);
  endtask

  initial begin
    vec_t v;

    addVec(1, F3_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    addVec(1, F3_W,  32'h0000_0014, 32'h4433_2211, 32'h0000_0000, 0);
    addVec(0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    addVec(0, F3_B,  32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 0);
    addVec(0, F3_BU, 32'h0000_0013, 32'h0,         32'h0000_00DE, 0);
    addVec(0, F3_H,  32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 0);
    addVec(0, F3_HU, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 0);
    addVec(0, F3_B,  32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 0);
    addVec(0, F3_BU, 32'h0000_0014, 32'h0,         32'h0000_0011, 0);
    addVec(1, F3_W,  32'h0000_0020, 32'h0BAD_F00D, 32'h0000_0000, 0);
    addVec(1, F3_W,  32'h0000_0030, 32'h0102_0304, 32'h0000_0000, 0);
    addVec(1, F3_H,  32'h0000_0032, 32'hFFFF_CAFE, 32'h0000_0000, 0);
    addVec(0, F3_W,  32'h0000_0030, 32'h0,         32'hCAFE_0304, 0);
    addVec(1, F3_B,  32'h0000_0031, 32'h1234_5677, 32'h0000_0000, 0);
    addVec(0, F3_W,  32'h0000_0030, 32'h0,         32'hCAFE_7704, 0);
    addVec(1, F3_W,  32'h0001_0010, 32'h1234_5678, 32'h0000_0000, 1);
    addVec(1, F3_W,  32'h0001_0000, 32'h1234_5678, 32'h0000_0000, 1);
    addVec(0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    addVec(0, 3'b011, 32'h0000_0010, 32'h0,        32'h0000_0000, 1);
    addVec(0, 3'b110, 32'h0000_0010, 32'h0,        32'h0000_0000, 1);
    addVec(1, 3'b011, 32'h0000_0010, 32'h0,        32'h0000_0000, 1);
    addVec(1, F3_BU, 32'h0000_0010, 32'h0,         32'h0000_0000, 1);
    addVec(0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    addVec(0, F3_W,  32'h0002_0010, 32'h0,         32'h0000_0000, 1);
    addVec(0, F3_W,  32'h0000_0011, 32'h0,         TRAP ? 32'h0 : 32'h11DE_ADBE, TRAP);
    addVec(0, F3_H,  32'h0000_0013, 32'h0,         TRAP ? 32'h0 : 32'h0000_11DE, TRAP);
    addVec(0, F3_H,  32'h0000_0011, 32'h0,         TRAP ? 32'h0 : 32'hFFFF_ADBE, TRAP);
    addVec(1, F3_H,  32'h0000_0033, 32'h0000_5555, 32'h0000_0000, TRAP);
    addVec(0, F3_W,  32'h0000_0030, 32'h0,         TRAP ? 32'hCAFE_7704 : 32'h55FE_7704, 0);
    addVec(1, F3_W,  32'h0000_FFFF, 32'hA1B2_C3D4, 32'h0000_0000, TRAP);
    addVec(0, F3_W,  32'h0000_FFFF, 32'h0,         TRAP ? 32'h0 : 32'hA1B2_C3D4, TRAP);

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    $display("[TB] reset state");
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);

    $display("[TB] vector table, %0d entries", vecs.size());
    foreach (vecs[i]) begin
      runOne(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] stalled response");
    v.we = 0; v.funct3 = F3_W; v.addr = 32'h10; v.wdata = 32'h0;
    v.expRdata = 32'hDEAD_BEEF; v.expErr = 0;
    applyStimulus(v, "stall");
    waitResponse("stall");
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h14;
    bus.req_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall c%0d rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
      check($sformatf("stall c%0d rdata", c), bus.rsp_rdata, 32'hDEAD_BEEF);
      check($sformatf("stall c%0d req_ready", c), {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    checkOutput("stall");

    $display("[TB] reset during wait states");
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h1111_1111;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rstwait in wait", {31'd0, bus.req_ready}, 32'd0);
    #1;
    rst = 1'b1;
    #2;
    check("rstwait req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstwait rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstwait later rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rstwait later req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstwait later rdata", bus.rsp_rdata, 32'd0);
    v.we = 0; v.funct3 = F3_W; v.addr = 32'h20; v.wdata = 32'h0;
    v.expRdata = 32'h0BAD_F00D; v.expErr = 0;
    runOne(v, "rstwait reload");

    check("scoreboard drained", scoreboard.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
